zacore_fetch_mem_bridge: RTL and testbench

ZACORE_FETCH_MEM_BRIDGE -- requirements
Module: zacore_fetch_mem_bridge

---
 rtl/zacore_fetch_mem_bridge.sv | 128 ++++++++++++
 tb/tb_zacore_fetch_mem_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zacore_fetch_mem_bridge.sv
`timescale 1ns/1ps
// Bridges the fetch stage to a single-outstanding memory port, with an optional one-word last-fetch buffer.
// Latency: buffer hit acks in the request cycle; a miss acks combinationally in the cycle rvalid arrives.
// Backpressure: o_mem_req is held until i_mem_gnt; fetch requests outside IDLE are not accepted.
module zacore_fetch_mem_bridge #(
    parameter bit BUFFER_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    output logic        o_fetch_ack,
    input  logic [31:0] i_fetch_addr,
    output logic [31:0] o_inst_read,
    input  logic        i_invalidate,
    input  logic        i_buf_flush,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic        buf_hit;
    logic        buf_load;
    logic [31:0] buf_dat;
    logic        unused_sigs;

    assign unused_sigs = ^{i_fetch_addr[1:0], i_buf_flush, buf_load};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        o_fetch_ack = 1'b0;
        o_inst_read = '0;
        buf_load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_fetch_req && !i_invalidate) begin
                    if (buf_hit) begin
                        o_fetch_ack = 1'b1;
                        o_inst_read = buf_dat;
                    end else begin
                        addr_d  = i_fetch_addr[31:2];
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    state_d = i_invalidate ? S_DISCARD : S_WAIT;
                end else if (i_invalidate) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                // Data returning alongside a flush is still worth keeping in the buffer.
                if (i_mem_rvalid) begin
                    buf_load = 1'b1;
                    state_d  = S_IDLE;
                    if (!i_invalidate) begin
                        o_fetch_ack = 1'b1;
                        o_inst_read = i_mem_rdata;
                    end
                end else if (i_invalidate) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (i_mem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_mem_req  = (state_q == S_REQ);
    assign o_mem_addr = {addr_q, 2'b00};

    generate
        if (BUFFER_EN) begin : g_buf
            logic        buf_vld_q;
            logic [29:0] buf_tag_q;
            logic [31:0] buf_dat_q;

            // Flush takes priority over a load landing in the same cycle.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    buf_vld_q <= 1'b0;
                    buf_tag_q <= '0;
                    buf_dat_q <= '0;
                end else if (i_buf_flush) begin
                    buf_vld_q <= 1'b0;
                end else if (buf_load) begin
                    buf_vld_q <= 1'b1;
                    buf_tag_q <= addr_q;
                    buf_dat_q <= i_mem_rdata;
                end
            end

            assign buf_hit = buf_vld_q && (buf_tag_q == i_fetch_addr[31:2]) && !i_buf_flush;
            assign buf_dat = buf_dat_q;
        end else begin : g_nobuf
            assign buf_hit = 1'b0;
            assign buf_dat = '0;
        end
    endgenerate

endmodule

// File: tb/tb_zacore_fetch_mem_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for zacore_fetch_mem_bridge: expected ack data is queued when stimulus is driven
// and popped by a negedge monitor; scenario tasks add their own inline cycle checks.
module tb_zacore_fetch_mem_bridge;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_fetch_req = 1'b0;
    logic        o_fetch_ack;
    logic [31:0] i_fetch_addr = '0;
    logic [31:0] o_inst_read;
    logic        i_invalidate = 1'b0;
    logic        i_buf_flush = 1'b0;
    logic        o_mem_req;
    logic        i_mem_gnt = 1'b0;
    logic [31:0] o_mem_addr;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    zacore_fetch_mem_bridge #(.BUFFER_EN(1'b1)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fetch_req  (i_fetch_req),
        .o_fetch_ack  (o_fetch_ack),
        .i_fetch_addr (i_fetch_addr),
        .o_inst_read  (o_inst_read),
        .i_invalidate (i_invalidate),
        .i_buf_flush  (i_buf_flush),
        .o_mem_req    (o_mem_req),
        .i_mem_gnt    (i_mem_gnt),
        .o_mem_addr   (o_mem_addr),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Every ack must match the oldest queued expectation; a non-ack cycle must read zero.
    always @(negedge i_clk) begin
        checks++;
        if (o_fetch_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: ack=1 inst=%h, required no ack", o_inst_read);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_inst_read !== mon_exp) begin
                    errors++;
                    $display("FAIL ack_data: got %h, required %h", o_inst_read, mon_exp);
                end
            end
        end else if (o_fetch_ack !== 1'b0 || o_inst_read !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs: ack=%b inst=%h, required ack=0 inst=0", o_fetch_ack, o_inst_read);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Full miss transaction: request, grant after gnt_dly cycles in REQ, rvalid rv_dly cycles after grant.
    task automatic miss_fetch(input logic [31:0] addr, input logic [31:0] data,
                              input int gnt_dly, input int rv_dly);
        i_fetch_req  = 1'b1;
        i_fetch_addr = addr;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0 || o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL miss_first_cycle: ack=%b mem_req=%b, required 0/0", o_fetch_ack, o_mem_req);
        end
        step();
        i_fetch_req  = 1'b0;
        i_fetch_addr = 32'hFFFF_FFF0;
        for (int i = 0; i <= gnt_dly; i++) begin
            i_mem_gnt = (i == gnt_dly);
            @(negedge i_clk);
            checks++;
            if (o_mem_req !== 1'b1 || o_mem_addr !== {addr[31:2], 2'b00}) begin
                errors++;
                $display("FAIL miss_req_hold: mem_req=%b addr=%h, required 1/%h",
                         o_mem_req, o_mem_addr, {addr[31:2], 2'b00});
            end
            step();
        end
        i_mem_gnt = 1'b0;
        for (int i = 1; i <= rv_dly; i++) begin
            i_mem_rvalid = (i == rv_dly);
            i_mem_rdata  = (i == rv_dly) ? data : 32'hA5A5_A5A5;
            if (i == rv_dly) exp_q.push_back(data);
            @(negedge i_clk);
            checks++;
            if (i == rv_dly) begin
                if (o_fetch_ack !== 1'b1 || o_inst_read !== data) begin
                    errors++;
                    $display("FAIL miss_ack: ack=%b inst=%h, required 1/%h", o_fetch_ack, o_inst_read, data);
                end
            end else if (o_fetch_ack !== 1'b0 || o_mem_req !== 1'b0) begin
                errors++;
                $display("FAIL miss_wait: ack=%b mem_req=%b, required 0/0", o_fetch_ack, o_mem_req);
            end
            step();
        end
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0 || o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL miss_single_pulse: ack=%b mem_req=%b, required 0/0", o_fetch_ack, o_mem_req);
        end
        step();
    endtask

    // Starts a miss and leaves the DUT in WAIT (grant given immediately).
    task automatic start_to_wait(input logic [31:0] addr);
        i_fetch_req  = 1'b1;
        i_fetch_addr = addr;
        step();
        i_fetch_req  = 1'b0;
        i_mem_gnt    = 1'b1;
        step();
        i_mem_gnt    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0 || o_inst_read !== 32'h0 || o_mem_req !== 1'b0 || o_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ack=%b inst=%h req=%b addr=%h, required all 0",
                     o_fetch_ack, o_inst_read, o_mem_req, o_mem_addr);
        end
        step();
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_miss();
        miss_fetch(32'h0000_1004, 32'h0013_0513, 2, 3);
    endtask

    task automatic test_hit();
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h0000_1006;
        exp_q.push_back(32'h0013_0513);
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b1 || o_inst_read !== 32'h0013_0513 || o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL hit_same_cycle: ack=%b inst=%h req=%b, required 1/00130513/0",
                     o_fetch_ack, o_inst_read, o_mem_req);
        end
        step();
        i_fetch_req = 1'b0;
        i_buf_flush = 1'b1;
        step();
        i_buf_flush = 1'b0;
        miss_fetch(32'h0000_1004, 32'h1111_1111, 0, 1);
    endtask

    task automatic test_inv_wait();
        start_to_wait(32'h0000_2000);
        i_invalidate = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0) begin
            errors++;
            $display("FAIL inv_wait_ack: ack=%b, required 0", o_fetch_ack);
        end
        step();
        i_invalidate = 1'b0;
        step();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_BEEF;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0) begin
            errors++;
            $display("FAIL discard_rvalid_ack: ack=%b, required 0", o_fetch_ack);
        end
        step();
        i_mem_rvalid = 1'b0;
        miss_fetch(32'h0000_2000, 32'h2222_2222, 1, 2);
    endtask

    task automatic test_inv_req();
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h0000_3000;
        step();
        i_fetch_req  = 1'b0;
        i_invalidate = 1'b1;
        step();
        i_invalidate = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL inv_req_drop: mem_req=%b, required 0", o_mem_req);
        end
        step();
        i_fetch_req  = 1'b1;
        step();
        i_fetch_req  = 1'b0;
        i_invalidate = 1'b1;
        i_mem_gnt    = 1'b1;
        step();
        i_invalidate = 1'b0;
        i_mem_gnt    = 1'b0;
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h0000_2000;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b0 || o_fetch_ack !== 1'b0) begin
            errors++;
            $display("FAIL discard_ignores_req: req=%b ack=%b, required 0/0", o_mem_req, o_fetch_ack);
        end
        step();
        i_fetch_req  = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h3333_3333;
        step();
        i_mem_rvalid = 1'b0;
        i_fetch_req  = 1'b1;
        exp_q.push_back(32'h2222_2222);
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b1 || o_inst_read !== 32'h2222_2222) begin
            errors++;
            $display("FAIL discard_no_load: ack=%b inst=%h, required 1/22222222", o_fetch_ack, o_inst_read);
        end
        step();
        i_fetch_req = 1'b0;
    endtask

    task automatic test_rvalid_inv();
        start_to_wait(32'h0000_4000);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h4444_4444;
        i_invalidate = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_inv_ack: ack=%b, required 0", o_fetch_ack);
        end
        step();
        i_mem_rvalid = 1'b0;
        i_invalidate = 1'b0;
        i_fetch_req  = 1'b1;
        exp_q.push_back(32'h4444_4444);
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b1 || o_inst_read !== 32'h4444_4444) begin
            errors++;
            $display("FAIL rvalid_inv_loaded: ack=%b inst=%h, required 1/44444444", o_fetch_ack, o_inst_read);
        end
        step();
        i_fetch_req = 1'b0;
    endtask

    task automatic test_flush_lookup();
        i_fetch_req  = 1'b1;
        i_fetch_addr = 32'h0000_4000;
        i_buf_flush  = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0) begin
            errors++;
            $display("FAIL flush_lookup_miss: ack=%b, required 0", o_fetch_ack);
        end
        step();
        i_fetch_req = 1'b0;
        i_buf_flush = 1'b0;
        i_mem_gnt   = 1'b1;
        step();
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h4545_4545;
        i_buf_flush  = 1'b1;
        exp_q.push_back(32'h4545_4545);
        step();
        i_mem_rvalid = 1'b0;
        i_buf_flush  = 1'b0;
        i_fetch_req  = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0) begin
            errors++;
            $display("FAIL flush_beats_load: ack=%b, required 0", o_fetch_ack);
        end
        step();
        i_fetch_req  = 1'b0;
        i_invalidate = 1'b1;
        step();
        i_invalidate = 1'b0;
        step();
    endtask

    task automatic test_rst_wait();
        start_to_wait(32'h0000_5000);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h5555_5555;
        #1;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_fetch_ack !== 1'b0 || o_inst_read !== 32'h0 || o_mem_req !== 1'b0 || o_mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ack=%b inst=%h req=%b addr=%h, required all 0",
                     o_fetch_ack, o_inst_read, o_mem_req, o_mem_addr);
        end
        i_mem_rvalid = 1'b0;
        step();
        i_rst        = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h6666_6666;
        @(negedge i_clk);
        checks++;
        if (o_fetch_ack !== 1'b0 || o_mem_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_rvalid: ack=%b req=%b, required 0/0", o_fetch_ack, o_mem_req);
        end
        step();
        i_mem_rvalid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_inv_wait();
        test_inv_req();
        test_rvalid_inv();
        test_flush_lookup();
        test_rst_wait();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: %0d expected acks never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
